// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
//
// Divides the unsigned dividend held in Q by the unsigned divisor held in M.
// After WIDTH iterations Q holds the quotient and R holds the remainder.
// A zero divisor skips the iteration and returns an all-ones quotient, with
// the dividend as the remainder and the sticky Div_zero flag set.
//
// Ports:
//   Clk       system clock, rising edge active
//   Reset_n   synchronous active-low reset
//   Load_A    in IDLE, load D into Q (dividend)
//   Load_B    in IDLE, load D into M (divisor)
//   Run       level; starts one division per assertion
//   D         operand data
//   Qval      Q register (dividend before a run, quotient after)
//   Rval      remainder R[WIDTH-1:0]
//   Mval      divisor register M
//   Busy      high while iterating
//   Done      high while the result is being presented
//   Div_zero  divisor was zero on the last start
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load_A,
  input  logic             Load_B,
  input  logic             Run,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qval,
  output logic [WIDTH-1:0] Rval,
  output logic [WIDTH-1:0] Mval,
  output logic             Busy,
  output logic             Done,
  output logic             Div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH:0]     r;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   m;
  logic [CNT_W-1:0]   cnt;
  logic               dz;

  logic               load_any;
  logic               last_iter;
  logic [WIDTH:0]     r_shift;
  logic [WIDTH:0]     r_diff;

  // Loads take priority over a start in the same cycle, so a start only ever
  // uses operands that were registered on an earlier edge.
  assign load_any  = Load_A | Load_B;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Upper half of {R,Q} << 1, then the trial subtraction. R < M holds between
  // iterations, so the shifted value fits in WIDTH+1 bits and the MSB of the
  // difference is a clean borrow indicator.
  assign r_shift = (r << 1) | (WIDTH + 1)'(q[WIDTH-1]);
  assign r_diff  = r_shift - {1'b0, m};

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Run && !load_any) next_state = (m == '0) ? DONE : CALC;
      end
      CALC: begin
        if (last_iter) next_state = DONE;
      end
      DONE: begin
        // Holding Run parks here so one assertion yields one division.
        if (!Run) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    case (state)
      CALC:    Busy = 1'b1;
      DONE:    Done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      q   <= '0;
      r   <= '0;
      m   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_any) begin
            if (Load_A) q <= D;
            if (Load_B) m <= D;
          end else if (Run) begin
            if (m != '0) begin
              r   <= '0;
              cnt <= '0;
              dz  <= 1'b0;
            end else begin
              q  <= '1;
              r  <= {1'b0, q};
              dz <= 1'b1;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CNT_W'(1);
          if (!r_diff[WIDTH]) begin
            r <= r_diff;
            q <= {q[WIDTH-2:0], 1'b1};
          end else begin
            r <= r_shift;
            q <= {q[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign Qval     = q;
  assign Rval     = r[WIDTH-1:0];
  assign Mval     = m;
  assign Div_zero = dz;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized bench for seq_divider (WIDTH=8).
// Expected results come from plain integer division of the operands the
// bench has loaded; the bench tracks which operands the divider holds.
module tb_seq_divider;

  localparam int W = 8;

  logic         Clk;
  logic         Reset_n;
  logic         Load_A;
  logic         Load_B;
  logic         Run;
  logic [W-1:0] D;
  logic [W-1:0] Qval;
  logic [W-1:0] Rval;
  logic [W-1:0] Mval;
  logic         Busy;
  logic         Done;
  logic         Div_zero;

  int total;
  int bad;

  // Operands the divider is expected to hold right now.
  logic [W-1:0] mdl_q;
  logic [W-1:0] mdl_m;

  seq_divider #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .Load_A   (Load_A),
    .Load_B   (Load_B),
    .Run      (Run),
    .D        (D),
    .Qval     (Qval),
    .Rval     (Rval),
    .Mval     (Mval),
    .Busy     (Busy),
    .Done     (Done),
    .Div_zero (Div_zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_ops(input logic [W-1:0] a, input logic [W-1:0] b);
    Load_A = 1'b1; Load_B = 1'b0; D = a;
    tick();
    Load_A = 1'b0; Load_B = 1'b1; D = b;
    tick();
    Load_B = 1'b0;
    mdl_q = a;
    mdl_m = b;
  endtask

  // One division of the currently held operands. hold_run keeps Run high
  // through DONE; junk drives loads with 0x55 during CALC/DONE.
  task automatic run_div(input string tag, input bit hold_run, input bit junk);
    logic [W-1:0] eq, er;
    logic         edz;
    int           n;
    int           want_busy;
    if (mdl_m == '0) begin
      eq = '1; er = mdl_q; edz = 1'b1; want_busy = 0;
    end else begin
      eq = mdl_q / mdl_m; er = mdl_q % mdl_m; edz = 1'b0; want_busy = W;
    end
    Run = 1'b1;
    tick();
    if (!hold_run) Run = 1'b0;
    if (junk) begin
      Load_A = 1'b1; Load_B = 1'b1; D = 8'h55;
    end
    n = 0;
    while (Busy === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    chk({tag, ".busy_cycles"}, n, want_busy);
    chk({tag, ".done"}, Done, 1'b1);
    chk({tag, ".q"}, Qval, eq);
    chk({tag, ".r"}, Rval, er);
    chk({tag, ".dz"}, Div_zero, edz);
    chk({tag, ".m"}, Mval, mdl_m);
    if (hold_run) begin
      repeat (25) tick();
      chk({tag, ".hold_done"}, Done, 1'b1);
      chk({tag, ".hold_busy"}, Busy, 1'b0);
      chk({tag, ".hold_q"}, Qval, eq);
    end
    Run = 1'b0;
    tick();
    Load_A = 1'b0; Load_B = 1'b0;
    chk({tag, ".idle_done"}, Done, 1'b0);
    chk({tag, ".idle_q"}, Qval, eq);
    chk({tag, ".idle_m"}, Mval, mdl_m);
    mdl_q = eq;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    total = 0;
    bad   = 0;
    mdl_q = '0;
    mdl_m = '0;
    Reset_n = 1'b0; Load_A = 1'b0; Load_B = 1'b0; Run = 1'b0; D = '0;
    tick();
    tick();
    chk("rst.q", Qval, 0);
    chk("rst.r", Rval, 0);
    chk("rst.m", Mval, 0);
    chk("rst.busy", Busy, 0);
    chk("rst.done", Done, 0);
    chk("rst.dz", Div_zero, 0);
    Reset_n = 1'b1;
    tick();

    load_ops(8'd100, 8'd7);
    run_div("d100_7", 1'b0, 1'b0);
    load_ops(8'd255, 8'd1);
    run_div("d255_1", 1'b0, 1'b0);
    load_ops(8'd5, 8'd9);
    run_div("d5_9", 1'b0, 1'b0);
    load_ops(8'd0, 8'd3);
    run_div("d0_3", 1'b0, 1'b0);

    // Divide by zero, then a valid run clears the flag.
    load_ops(8'd200, 8'd0);
    run_div("dz200", 1'b0, 1'b0);
    load_ops(8'd9, 8'd4);
    run_div("after_dz", 1'b0, 1'b0);

    // Held Run gives one division; re-run chains on the quotient (14/7).
    load_ops(8'd100, 8'd7);
    run_div("hold", 1'b1, 1'b0);
    run_div("chain", 1'b0, 1'b0);

    // Loads during CALC and DONE are ignored.
    load_ops(8'd100, 8'd7);
    run_div("junk", 1'b0, 1'b1);
    load_ops(8'd77, 8'd5);
    run_div("junk_hold", 1'b1, 1'b1);

    // Load and Run together: load wins, no start.
    Run = 1'b1; Load_A = 1'b1; D = 8'd50;
    tick();
    Load_A = 1'b0; Run = 1'b0;
    mdl_q = 8'd50;
    chk("ldrun.busy", Busy, 0);
    chk("ldrun.done", Done, 0);
    chk("ldrun.q", Qval, 8'd50);
    run_div("ldrun_div", 1'b0, 1'b0);

    // Reset during iteration 4.
    load_ops(8'd100, 8'd7);
    Run = 1'b1;
    tick();
    Run = 1'b0;
    tick(); tick(); tick();
    chk("midrst.pre_busy", Busy, 1);
    Reset_n = 1'b0;
    tick();
    chk("midrst.q", Qval, 0);
    chk("midrst.r", Rval, 0);
    chk("midrst.m", Mval, 0);
    chk("midrst.busy", Busy, 0);
    chk("midrst.done", Done, 0);
    chk("midrst.dz", Div_zero, 0);
    Run = 1'b1;
    tick(); tick(); tick();
    chk("rsthold.busy", Busy, 0);
    chk("rsthold.done", Done, 0);
    // Release with Run high: M is zero, so the start takes the zero path.
    Reset_n = 1'b1;
    tick();
    chk("rstrel.done", Done, 1);
    chk("rstrel.dz", Div_zero, 1);
    chk("rstrel.q", Qval, 8'hFF);
    chk("rstrel.r", Rval, 0);
    Run = 1'b0;
    tick();
    chk("rstrel.idle", Done, 0);
    mdl_q = 8'hFF;
    mdl_m = '0;

    // Randomized operands, including an occasional zero divisor.
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      load_ops(ra, rb);
      run_div($sformatf("rnd%0d", i), 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
